// File: rtl/charram_dram_sequencer.sv
// Character-RAM DRAM sequencer: drives RAS/CAS/WR/RD and the multiplexed address of one
// 16Kx4 plane. Each 4-cycle slot goes to video (reserved slot 0 of the period), the CPU,
// or RAS-only refresh. Every output is registered.
module charram_dram_sequencer #(
  parameter int unsigned VID_SLOT_PERIOD = 2,
  parameter bit          REFRESH_EN      = 1'b1
) (
  input  logic        i_MCLK,
  input  logic        i_RST_n,
  input  logic        i_VID_EN,
  input  logic        i_VID_REQ,
  input  logic [13:0] i_VID_ADDR,
  output logic [3:0]  o_VID_DOUT,
  output logic        o_VID_VALID,
  input  logic        i_CPU_REQ,
  input  logic        i_CPU_WR,
  input  logic [13:0] i_CPU_ADDR,
  input  logic [3:0]  i_CPU_DIN,
  output logic [3:0]  o_CPU_DOUT,
  output logic        o_CPU_ACK,
  output logic [7:0]  o_ADDR,
  output logic [3:0]  o_DIN,
  input  logic [3:0]  i_DRAM_DOUT,
  output logic        o_RAS_n,
  output logic        o_CAS_n,
  output logic        o_WR_n,
  output logic        o_RD_n
);

  typedef enum logic [1:0] {StP0, StP1, StP2, StP3} phase_e;
  typedef enum logic [1:0] {OwnIdle, OwnRfsh, OwnVid, OwnCpu} owner_e;

  localparam logic [2:0] LastSlot = 3'(VID_SLOT_PERIOD - 1);

  phase_e      phase_q, phase_d;
  owner_e      own_q, own_d, own_tent;
  logic [2:0]  slot_q, slot_d;
  logic [7:0]  rfsh_q, rfsh_d;
  logic [13:0] acc_addr_q, acc_addr_d;
  logic        acc_wr_q, acc_wr_d;
  logic [3:0]  acc_din_q, acc_din_d;
  logic        cpu_busy_q, cpu_busy_d;
  logic        access;

  logic [7:0]  addr_d;
  logic [3:0]  din_d, vid_dout_d, cpu_dout_d;
  logic        ras_n_d, cas_n_d, wr_n_d, rd_n_d, vid_valid_d, cpu_ack_d;

  function automatic owner_e pick_owner(input logic vid_slot, input logic vid_en,
                                        input logic vid_req, input logic cpu_req);
    if (vid_slot && vid_en && vid_req) return OwnVid;
    else if (cpu_req)                  return OwnCpu;
    else if (REFRESH_EN)               return OwnRfsh;
    else                               return OwnIdle;
  endfunction

  // Next-state for phase/slot/ownership and the registered strobe/address/data outputs.
  always_comb begin
    phase_d    = phase_e'(phase_q + 2'd1);
    slot_d     = slot_q;
    own_d      = own_q;
    own_tent   = OwnIdle;
    rfsh_d     = rfsh_q;
    acc_addr_d = acc_addr_q;
    acc_wr_d   = acc_wr_q;
    acc_din_d  = acc_din_q;
    cpu_busy_d = cpu_busy_q;
    vid_dout_d = o_VID_DOUT;
    cpu_dout_d = o_CPU_DOUT;
    vid_valid_d = 1'b0;
    cpu_ack_d   = 1'b0;
    ras_n_d     = 1'b1;
    cas_n_d     = 1'b1;
    wr_n_d      = 1'b1;
    rd_n_d      = 1'b1;
    addr_d      = o_ADDR;

    // The request line stays high through the ack cycle; it only counts again afterwards.
    if (o_CPU_ACK) cpu_busy_d = 1'b0;

    unique case (phase_q)
      StP0: begin
        // Retire the previous slot: its read data is on the DRAM pins during this P0.
        if (own_q == OwnVid) begin
          vid_dout_d  = i_DRAM_DOUT;
          vid_valid_d = 1'b1;
        end
        if (own_q == OwnCpu) begin
          cpu_ack_d = 1'b1;
          if (!acc_wr_q) cpu_dout_d = i_DRAM_DOUT;
        end
        own_d = pick_owner(slot_q == 3'd0, i_VID_EN, i_VID_REQ, i_CPU_REQ && !cpu_busy_q);
        if (own_d == OwnVid) begin
          acc_addr_d = i_VID_ADDR;
          acc_wr_d   = 1'b0;
          acc_din_d  = 4'h0;
        end else if (own_d == OwnCpu) begin
          acc_addr_d = i_CPU_ADDR;
          acc_wr_d   = i_CPU_WR;
          acc_din_d  = i_CPU_DIN;
          cpu_busy_d = 1'b1;
        end
      end
      StP3: begin
        slot_d = (slot_q == LastSlot) ? 3'd0 : slot_q + 3'd1;
        if (own_q == OwnRfsh) rfsh_d = rfsh_q + 8'd1;
      end
      default: ;
    endcase

    access = (own_d == OwnVid) || (own_d == OwnCpu);
    din_d  = (phase_d != StP0 && own_d == OwnCpu && acc_wr_d) ? acc_din_d : 4'h0;

    unique case (phase_d)
      StP0: begin
        // Precharge: present the row of whoever would win the coming slot right now.
        own_tent = pick_owner(slot_d == 3'd0, i_VID_EN, i_VID_REQ, i_CPU_REQ && !cpu_busy_q);
        if (own_tent == OwnVid)      addr_d = i_VID_ADDR[7:0];
        else if (own_tent == OwnCpu) addr_d = i_CPU_ADDR[7:0];
        else                         addr_d = rfsh_d;
      end
      StP1: begin
        ras_n_d = (own_d == OwnIdle);
        addr_d  = access ? acc_addr_d[7:0] : rfsh_q;
      end
      StP2: begin
        ras_n_d = (own_d == OwnIdle);
        cas_n_d = !access;
        addr_d  = access ? {1'b0, acc_addr_d[13:8], 1'b0} : rfsh_q;
      end
      StP3: begin
        ras_n_d = (own_d == OwnIdle);
        cas_n_d = !access;
        rd_n_d  = !(access && !acc_wr_d);
        wr_n_d  = !(access && acc_wr_d);
        addr_d  = access ? {1'b0, acc_addr_d[13:8], 1'b0} : rfsh_q;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access without an ack.
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      phase_q     <= StP0;
      own_q       <= OwnIdle;
      slot_q      <= 3'd0;
      rfsh_q      <= 8'd0;
      acc_addr_q  <= 14'd0;
      acc_wr_q    <= 1'b0;
      acc_din_q   <= 4'h0;
      cpu_busy_q  <= 1'b0;
      o_RAS_n     <= 1'b1;
      o_CAS_n     <= 1'b1;
      o_WR_n      <= 1'b1;
      o_RD_n      <= 1'b1;
      o_ADDR      <= 8'd0;
      o_DIN       <= 4'h0;
      o_VID_DOUT  <= 4'h0;
      o_VID_VALID <= 1'b0;
      o_CPU_DOUT  <= 4'h0;
      o_CPU_ACK   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      own_q       <= own_d;
      slot_q      <= slot_d;
      rfsh_q      <= rfsh_d;
      acc_addr_q  <= acc_addr_d;
      acc_wr_q    <= acc_wr_d;
      acc_din_q   <= acc_din_d;
      cpu_busy_q  <= cpu_busy_d;
      o_RAS_n     <= ras_n_d;
      o_CAS_n     <= cas_n_d;
      o_WR_n      <= wr_n_d;
      o_RD_n      <= rd_n_d;
      o_ADDR      <= addr_d;
      o_DIN       <= din_d;
      o_VID_DOUT  <= vid_dout_d;
      o_VID_VALID <= vid_valid_d;
      o_CPU_DOUT  <= cpu_dout_d;
      o_CPU_ACK   <= cpu_ack_d;
    end
  end

endmodule

// File: doc/charram_dram_sequencer.md
Name: charram_dram_sequencer

Overview:
Sequences the four control strobes and the multiplexed row/column address of one 4416-style 16Kx4 character-RAM DRAM plane. Time-shares the plane between two requesters:
- the video pixel fetcher, which gets guaranteed periodic slots;
- the CPU, which gets the remaining slots and a DTACK-style acknowledge.

Slots that no requester uses perform RAS-only refresh. The block sits between the CPU/video address logic and the DRAM plane's ADDR/RAS/CAS/WR/RD pins.

Parameters:
VID_SLOT_PERIOD, 2, one slot in every VID_SLOT_PERIOD slots is reserved for video (slot index 0 of the period); legal range 1..8.
REFRESH_EN, 1, 1 = idle slots issue RAS-only refresh; 0 = idle slots leave RAS_n high.

Ports:
i_MCLK  in  1  master clock; all state updates on its rising edge
i_RST_n  in  1  asynchronous active-low reset
i_VID_EN  in  1  1 = video slots reserved; 0 (blanking) = every slot is available to the CPU
i_VID_REQ  in  1  video fetch request, sampled in P0 of a video slot
i_VID_ADDR  in  14  video word address {col[5:0],row[7:0]}
o_VID_DOUT  out  4  captured video nibble
o_VID_VALID  out  1  one-cycle pulse when o_VID_DOUT is updated
i_CPU_REQ  in  1  CPU request; level, held until ack
i_CPU_WR  in  1  1 = write, 0 = read; sampled with the request
i_CPU_ADDR  in  14  CPU word address {col[5:0],row[7:0]}
i_CPU_DIN  in  4  CPU write nibble
o_CPU_DOUT  out  4  CPU read nibble
o_CPU_ACK  out  1  one-cycle acknowledge pulse
o_ADDR  out  8  DRAM multiplexed address
o_DIN  out  4  DRAM write data
i_DRAM_DOUT  in  4  DRAM read data (registered inside the DRAM)
o_RAS_n, o_CAS_n, o_WR_n, o_RD_n  out  1 each  DRAM strobes

Behaviour:
- 2-bit phase counter cycles P0..P3; 4 MCLK cycles = 1 slot. Slot counter runs modulo VID_SLOT_PERIOD.
- All outputs are registered. The strobe levels below are the values held during each phase.
- P0, precharge: RAS_n=1, CAS_n=1, WR_n=1, RD_n=1. Owner is decided at the end of P0. o_ADDR = row of the selected address.
- Ownership priority:
  1. Video slot with i_VID_EN=1 and i_VID_REQ=1 -> video.
  2. Otherwise, i_CPU_REQ=1 -> CPU. This includes video slots while i_VID_EN=0 or while i_VID_REQ=0.
  3. Otherwise -> refresh (or idle if REFRESH_EN=0).
- Address, WR and DIN are latched at the grant.
- P1: RAS_n=0, CAS_n=1, o_ADDR = row[7:0].
- P2: RAS_n=0, CAS_n=0, o_ADDR = {1'b0, col[5:0], 1'b0}.
- P3: RAS_n=0, CAS_n=0, column address held.
  - Read: RD_n=0.
  - Write: WR_n=0 and o_DIN = latched data.
- Refresh slot: RAS_n=0 in P1..P3; CAS/WR/RD held high; o_ADDR = refresh row counter. The 8-bit counter increments (wrapping 255->0) at the end of each refresh slot.
- Idle slot (REFRESH_EN=0): all strobes high.
- Read latency:
  - DRAM output is valid during the following slot's P0.
  - The block captures it at the end of that P0.
  - o_*_DOUT updates, and o_VID_VALID or o_CPU_ACK pulses high, for exactly the following P1 cycle.
- Write ack: o_CPU_ACK pulses in the following slot's P1, matching read timing.
- CPU request handling:
  - Only one CPU access per request.
  - The request is ignored from the grant until the ack cycle inclusive. The CPU drops i_CPU_REQ after seeing the ack.
  - If i_CPU_REQ drops after the grant, the access still completes and the ack still pulses.
- Video: a video slot with i_VID_REQ=0 and no CPU request falls to refresh.
- Reset, asserted at any time:
  - phase=P0, slot counter=0, refresh counter=0;
  - RAS_n=CAS_n=WR_n=RD_n=1; o_ADDR=0, o_DIN=0, DOUTs=0, VALID=0, ACK=0;
  - any in-flight access is abandoned with no ack. A still-held CPU request is served after reset.
- Worst-case CPU latency from the request to the ack:
  - 4*VID_SLOT_PERIOD+6 cycles with i_VID_EN=1;
  - 10 cycles with i_VID_EN=0.

Test Plan:
- Reset release, no requests, REFRESH_EN=1: every slot is a refresh. RAS_n low in P1..P3 and CAS_n always high. o_ADDR steps 0,1,2...; after 256 slots it wraps to 0.
- Video read at addr 0x2A5C (col 0x2A, row 0x5C), memory holds 0x9 there:
  - o_ADDR=0x5C in P1 and 0x54 in P2/P3;
  - RD_n low in P3 only;
  - o_VID_DOUT=0x9 with VALID pulse in P1 of the next slot.
- CPU write 0x7 to 0x0103, then CPU read of the same address: WR_n low for one cycle in the write's P3, the read returns 0x7, and each access gives exactly one ACK pulse.
- VID_SLOT_PERIOD=2, i_VID_EN=1, video and CPU both requesting continuously: slots alternate video/CPU and the CPU is never granted a slot-0. Then drop i_VID_EN: the CPU gets consecutive slots.
- CPU request dropped one cycle after the grant: access completes, ack still pulses once, and there is no second access.
- Assert i_RST_n during P2 of a CPU read: strobes go high asynchronously, no ack is issued, and the held request is acknowledged after reset within 10 cycles with i_VID_EN=0.
